// File: rtl/psm_decoder.sv
// PSM decoder: syncs both channels, measures ch0 period, ch1 phase and leading channel.
// Results register 3 edges after the ch0 sampling edge; oStrobe pulses for one cycle, no backpressure.
module psm_decoder #(
  parameter int unsigned MAX_PERIOD = 65535
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  iPSM,
  output logic [15:0] oFREQUENCY,
  output logic [14:0] oANGLE,
  output logic        oDIRECT,
  output logic        oValid,
  output logic        oStrobe,
  output logic        oTimeout
);

  localparam logic [1:0]  S_WAIT  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_CALC  = 2'd2;
  localparam logic [15:0] MAX_CNT = 16'(MAX_PERIOD);

  logic [1:0]  sync1_q, sync2_q, hist_q;
  logic        rise0, rise1;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] d_cap_q, d_cap_d;
  logic        d_seen_q, d_seen_d;
  logic [15:0] p_cap_q, p_cap_d;
  logic [15:0] calc_d_q, calc_d_d;
  logic        calc_seen_q, calc_seen_d;

  logic [15:0] freq_q, freq_d;
  logic [14:0] angle_q, angle_d;
  logic        dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic        tmo_q, tmo_d;

  logic        timeout_hit;
  logic [16:0] twice_d;
  logic [15:0] ang_full;
  logic        unused_ang_msb;

  // Reset to 1 so an input already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= iPSM;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise0 = sync2_q[0] & ~hist_q[0];
  assign rise1 = sync2_q[1] & ~hist_q[1];

  always_comb begin
    cnt_d = cnt_q;
    if (rise0) begin
      cnt_d = 16'd1;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q != S_WAIT) && !rise0 && (cnt_q >= MAX_CNT);

  // Phase folded onto the shorter side of the period; the tie 2*d == P reports ch0 leading.
  assign twice_d        = {calc_d_q, 1'b0};
  assign ang_full       = (twice_d <= {1'b0, p_cap_q}) ? calc_d_q : (p_cap_q - calc_d_q);
  assign unused_ang_msb = ang_full[15];

  always_comb begin
    state_d     = state_q;
    d_cap_d     = d_cap_q;
    d_seen_d    = d_seen_q;
    p_cap_d     = p_cap_q;
    calc_d_d    = calc_d_q;
    calc_seen_d = calc_seen_q;
    freq_d      = freq_q;
    angle_d     = angle_q;
    dir_d       = dir_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    tmo_d       = tmo_q;

    case (state_q)
      S_WAIT: begin
        if (rise0) begin
          state_d  = S_RUN;
          d_cap_d  = 16'd0;
          d_seen_d = rise1;
        end
      end

      S_RUN: begin
        if (rise0) begin
          p_cap_d     = cnt_q;
          calc_d_d    = d_cap_q;
          calc_seen_d = d_seen_q;
          // A coincident rise1 opens the new period at phase 0.
          d_cap_d     = 16'd0;
          d_seen_d    = rise1;
          state_d     = S_CALC;
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_WAIT;
        end else if (rise1 && !d_seen_q) begin
          d_cap_d  = cnt_q;
          d_seen_d = 1'b1;
        end
      end

      S_CALC: begin
        if (timeout_hit) begin
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_WAIT;
        end else begin
          freq_d   = p_cap_q;
          valid_d  = calc_seen_q;
          tmo_d    = 1'b0;
          strobe_d = 1'b1;
          if (calc_seen_q) begin
            angle_d = ang_full[14:0];
            dir_d   = (twice_d > {1'b0, p_cap_q});
          end else begin
            angle_d = 15'd0;
          end
          if (rise1 && !d_seen_q) begin
            d_cap_d  = cnt_q;
            d_seen_d = 1'b1;
          end
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_WAIT;
      cnt_q       <= 16'd0;
      d_cap_q     <= 16'd0;
      d_seen_q    <= 1'b0;
      p_cap_q     <= 16'd0;
      calc_d_q    <= 16'd0;
      calc_seen_q <= 1'b0;
      freq_q      <= 16'd0;
      angle_q     <= 15'd0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_cap_q     <= d_cap_d;
      d_seen_q    <= d_seen_d;
      p_cap_q     <= p_cap_d;
      calc_d_q    <= calc_d_d;
      calc_seen_q <= calc_seen_d;
      freq_q      <= freq_d;
      angle_q     <= angle_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      tmo_q       <= tmo_d;
    end
  end

  assign oFREQUENCY = freq_q;
  assign oANGLE     = angle_q;
  assign oDIRECT    = dir_q;
  assign oValid     = valid_q;
  assign oStrobe    = strobe_q;
  assign oTimeout   = tmo_q;

endmodule

// File: tb/tb_psm_decoder.sv
// Directed bench for psm_decoder: per-period expectations queued at each ch0 rise, checked on oStrobe.
module tb_psm_decoder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  psm;
  logic [15:0] oFREQUENCY;
  logic [14:0] oANGLE;
  logic        oDIRECT, oValid, oStrobe, oTimeout;

  always #5 clk = ~clk;

  psm_decoder #(.MAX_PERIOD(100)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .iPSM      (psm),
    .oFREQUENCY(oFREQUENCY),
    .oANGLE    (oANGLE),
    .oDIRECT   (oDIRECT),
    .oValid    (oValid),
    .oStrobe   (oStrobe),
    .oTimeout  (oTimeout)
  );

  typedef struct {
    int unsigned freq;
    int unsigned ang;
    bit          dir;
    bit          vld;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  int   pushes  = 0;
  bit   armed   = 1'b0;
  int   prev_p, prev_d;
  bit   prev_en;
  bit   model_dir = 1'b0;
  int   s_mark;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int p, input int d, input bit en);
    exp_t e;
    e.freq = p;
    if (!en) begin
      e.vld = 1'b0; e.ang = 0; e.dir = model_dir;
    end else if (2 * d <= p) begin
      e.vld = 1'b1; e.ang = d; e.dir = 1'b0;
    end else begin
      e.vld = 1'b1; e.ang = p - d; e.dir = 1'b1;
    end
    model_dir = e.dir;
    sb.push_back(e);
    pushes++;
  endtask

  // One ch0 period: ch0 high for p/2 cycles, ch1 a one-cycle pulse d cycles after ch0 rises.
  task automatic drive_period(input int p, input int d, input bit en, input int rst_at);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (armed) push_exp(prev_p, prev_d, prev_en);
        armed = 1'b1; prev_p = p; prev_d = d; prev_en = en;
      end
      psm[0] = (c < p / 2);
      psm[1] = en && (c == d);
      if (c == rst_at) begin
        n_rst = 1'b0; armed = 1'b0; model_dir = 1'b0;
      end else begin
        n_rst = 1'b1;
      end
    end
  endtask

  task automatic drive_seg(input int p, input int d, input bit en, input int n);
    for (int i = 0; i < n; i++) drive_period(p, d, en, -1);
  endtask

  task automatic idle(input int n);
    armed = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psm = 2'b00; n_rst = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freq"},   32'(oFREQUENCY), 0);
    chk({tag, "_angle"},  32'(oANGLE),     0);
    chk({tag, "_dir"},    32'(oDIRECT),    0);
    chk({tag, "_valid"},  32'(oValid),     0);
    chk({tag, "_strobe"}, 32'(oStrobe),    0);
    chk({tag, "_tmo"},    32'(oTimeout),   0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (oStrobe === 1'b1) begin
      strobes++;
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("strobe_freq",  32'(oFREQUENCY), e.freq);
        chk("strobe_angle", 32'(oANGLE),     e.ang);
        chk("strobe_dir",   32'(oDIRECT),    32'(e.dir));
        chk("strobe_valid", 32'(oValid),     32'(e.vld));
        chk("strobe_tmo",   32'(oTimeout),   0);
      end
    end
  end

  initial begin
    n_rst = 1'b0;
    psm   = 2'b00;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    drive_seg(10, 3, 1'b1, 4);   // ch1 lags 3
    drive_seg(10, 7, 1'b1, 3);   // ch0 lags 3
    drive_seg(10, 0, 1'b1, 2);   // coincident
    drive_seg(10, 5, 1'b1, 2);   // exactly half period
    drive_seg(2,  1, 1'b1, 4);   // minimum period
    drive_seg(10, 7, 1'b1, 2);
    drive_seg(10, 0, 1'b0, 3);   // ch1 absent: dir holds 1
    drive_seg(10, 4, 1'b1, 3);

    idle(80);
    chk("pre_timeout_tmo",   32'(oTimeout), 0);
    chk("pre_timeout_valid", 32'(oValid),   1);
    idle(30);
    chk("timeout_tmo",   32'(oTimeout),   1);
    chk("timeout_valid", 32'(oValid),     0);
    chk("timeout_freq",  32'(oFREQUENCY), 10);
    chk("timeout_angle", 32'(oANGLE),     4);
    chk("timeout_dir",   32'(oDIRECT),    0);

    s_mark = strobes;
    drive_period(20, 6, 1'b1, -1);
    chk("restart_no_strobe",  32'(strobes),  32'(s_mark));
    chk("restart_tmo_sticky", 32'(oTimeout), 1);
    drive_seg(20, 6, 1'b1, 2);

    drive_seg(10, 3, 1'b1, 2);
    drive_period(10, 3, 1'b1, 6);
    chk_all_zero("midrst");
    s_mark = strobes;
    drive_period(10, 3, 1'b1, -1);
    chk("postrst_no_strobe", 32'(strobes), 32'(s_mark));
    drive_seg(10, 3, 1'b1, 2);
    idle(8);

    chk("sb_drained",   32'(sb.size()), 0);
    chk("strobe_count", 32'(strobes),   32'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
